config_frame_writer: RTL and testbench
======================================

Name: config_frame_writer

Overview:
- Write-side master for one column of frame-latch configuration memory.
- Accepts a 32-bit configuration word stream over a valid/ready handshake and parses sync, header and data words.
- Drives `FrameData`, plus a one-hot, single-cycle `FrameStrobe` pulse with setup and hold margins around it.
- Sits between the configuration loader (UART/bitbang/SPI front end) and the per-tile ConfigMem latch arrays of a column.

Parameters:
- `MaxFramesPerCol`, 20, number of frame strobes (frames) per column.
- `FrameBitsPerRow`, 32, `FrameData` width; equals the input word width.
- `SyncWord`, 32'hFAB0_FAB1, word that opens a configuration transaction.

Ports:
- `CLK`  input  1  single clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `WordData`  input  32  incoming configuration word.
- `WordValid`  input  1  `WordData` is valid.
- `WordReady`  output  1  block accepts `WordData` this cycle.
- `FrameData`  output  `FrameBitsPerRow`  frame contents presented to the latches.
- `FrameStrobe`  output  `MaxFramesPerCol`  one-hot latch enable; all zero when idle.
- `Busy`  output  1  a transaction is in progress (any state except `HUNT`).
- `Error`  output  1  sticky error flag.
- `Done`  output  1  one-cycle pulse when the last frame of a transaction completes its hold cycle.

Behaviour:
- Handshake:
  - A word is accepted on a rising edge with `WordValid` && `WordReady`.
  - `WordReady` is 1 in `HUNT`, `HEADER` and `DATA`; it is 0 in `SETUP`, `STROBE` and `HOLD`.
- States: `HUNT`, `HEADER`, `DATA`, `SETUP`, `STROBE`, `HOLD`.
- `HUNT`:
  - Accepted word == `SyncWord` -> `HEADER` and clear `Error`.
  - Any other word is discarded; stay in `HUNT`.
- `HEADER` (accepted word):
  - `idx` = `WordData[7:0]`, `cnt` = `WordData[15:8]`.
  - `cnt` == 0 -> `HUNT`; no writes and no error.
  - `idx` >= `MaxFramesPerCol` -> set `Error`, go to `DATA` in drop mode.
  - Otherwise -> `DATA`, with the remaining count loaded to `cnt`.
- `DATA` (accepted word):
  - Latch the word into the `FrameData` register, then `SETUP`.
  - In drop mode the word is consumed without a strobe: decrement the remaining count; at 0 -> `HUNT`, with no `Done`.
- `SETUP` (1 cycle): `FrameData` stable, `FrameStrobe` = 0.
- `STROBE` (1 cycle): `FrameStrobe[idx]` = 1, all other strobe bits 0.
- `HOLD` (1 cycle):
  - `FrameStrobe` = 0; `FrameData` unchanged.
  - Decrement the remaining count and increment `idx`.
  - Remaining count == 0 -> pulse `Done`, go to `HUNT`.
  - Incremented `idx` == `MaxFramesPerCol` with words still remaining -> set `Error` and switch to drop mode for those words.
  - Otherwise -> `DATA`.
- Timing and throughput:
  - Minimum 4 cycles per written frame (`DATA` accept + `SETUP` + `STROBE` + `HOLD`).
  - Strobe rises 2 edges after the accepting edge.
- Output registering:
  - `FrameStrobe` is a registered output and is never glitching.
  - At most one bit is set, for exactly one cycle per written frame.
  - `FrameData` changes only on a `DATA` accept and holds through `HOLD` and any following idle.
- Reset values:
  - `FrameData` = 0, `FrameStrobe` = 0, `WordReady` = 0 while reset is asserted, `Busy` = 0, `Error` = 0, `Done` = 0.
  - State returns to `HUNT`.
  - Reset asserted mid-`STROBE` clears the strobe immediately (asynchronously); the latches retain whatever was captured.
- Ignored inputs: `WordValid` while `WordReady` = 0 is ignored; the source must hold the word.
- Index width: `idx` is a `$clog2(MaxFramesPerCol)+1`-bit counter, so the comparison with `MaxFramesPerCol` cannot wrap.
- Header bits [31:16] are reserved; they are ignored and no error is raised.

Decomposition:
- Shared package `config_pkg`:
  - `SYNC_WORD` constant.
  - Header field positions (`IDX_LSB`/`MSB`, `CNT_LSB`/`MSB`).
  - FSM state enum `cfg_state_t`.
- Sub-module `frame_strobe_decoder`: registered binary-to-one-hot decoder with enable, driving `FrameStrobe`, async-reset to 0.
- Everything else lives in the top FSM.

Test Plan:
- Reset, then sync, header `idx`=3 `cnt`=1, data 32'hDEADBEEF -> `FrameData`=32'hDEADBEEF; `FrameStrobe`=20'h00008 for exactly one cycle, 2 edges after accept; `Done` pulses; `Error`=0.
- Sync, header `idx`=18 `cnt`=3, data A, B, C -> strobes bit 18 (A), then bit 19 (B); C is consumed with no strobe; `Error`=1; no `Done`; back in `HUNT`.
- Words 32'h0, 32'h12345678, then sync, header `cnt`=0 -> no strobes; `Busy` returns to 0; `Error`=0.
- Header `idx`=25 `cnt`=2 -> `Error`=1, two data words dropped, `FrameStrobe` never nonzero; a following valid sync clears `Error`.
- `WordValid` held high continuously with 4 data words to `idx`=0 -> `WordReady` pattern 1,0,0,0 per frame; strobes 0,1,2,3 in order, 4 cycles apart.
- Assert `reset` during a `STROBE` cycle -> `FrameStrobe`=0 in the same cycle (async); after release the block is in `HUNT` with `Busy`=0 and the next transaction works normally.

Source files
------------

// File: rtl/config_pkg.sv
// ---------------------------------------------------------------------------
// config_pkg
// Shared definitions for the column configuration frame writer:
//   SYNC_WORD        - word that opens a configuration transaction
//   IDX_LSB/IDX_MSB  - header field holding the first frame index
//   CNT_LSB/CNT_MSB  - header field holding the number of data words
//   cfg_state_t      - writer FSM states
// ---------------------------------------------------------------------------
package config_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    localparam int IDX_LSB = 0;
    localparam int IDX_MSB = 7;
    localparam int CNT_LSB = 8;
    localparam int CNT_MSB = 15;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        SETUP  = 3'd3,
        STROBE = 3'd4,
        HOLD   = 3'd5
    } cfg_state_t;

endpackage

// File: rtl/config_frame_writer_strobe_decoder.sv
// ---------------------------------------------------------------------------
// frame_strobe_decoder
// Registered binary-to-one-hot decoder. When en is high on a rising edge the
// bit selected by idx is set for the following cycle; otherwise all bits are
// cleared. Each bit is a flop, so the strobes never glitch.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset, clears all strobes at once
//   en     - load a one-hot pattern on the next edge
//   idx    - index of the bit to set
//   strobe - registered one-hot strobe vector
// ---------------------------------------------------------------------------
module frame_strobe_decoder #(
    parameter int Width = 20,
    parameter int IdxW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IdxW-1:0]  idx,
    output logic [Width-1:0] strobe
);

    logic [Width-1:0] strobeReg;

    generate
        for (genvar gi = 0; gi < Width; gi++) begin : g_bit
            localparam logic [IdxW-1:0] BitIdx = IdxW'(gi);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    strobeReg[gi] <= 1'b0;
                end else begin
                    strobeReg[gi] <= en && (idx == BitIdx);
                end
            end
        end
    endgenerate

    assign strobe = strobeReg;

endmodule

// File: rtl/config_frame_writer.sv
// ---------------------------------------------------------------------------
// config_frame_writer
// Write-side master for one column of frame-latch configuration memory.
// Parses a stream of 32-bit words (sync, header, data) and for every data
// word presents FrameData, then pulses exactly one FrameStrobe bit for one
// cycle, with one setup cycle before and one hold cycle after the strobe.
// Ports:
//   CLK         - clock, all state changes on the rising edge
//   reset       - asynchronous active-high reset
//   WordData    - incoming configuration word
//   WordValid   - WordData is valid
//   WordReady   - word is accepted this cycle when WordValid is also high
//   FrameData   - frame contents presented to the latches
//   FrameStrobe - one-hot latch enable, zero when idle
//   Busy        - transaction in progress (not hunting for sync)
//   Error       - sticky error, cleared by the next sync word
//   Done        - one-cycle pulse after the last frame's hold cycle
// ---------------------------------------------------------------------------
module config_frame_writer
    import config_pkg::*;
#(
    parameter int          MaxFramesPerCol = 20,
    parameter int          FrameBitsPerRow = 32,
    parameter logic [31:0] SyncWord        = SYNC_WORD
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [31:0]                WordData,
    input  logic                       WordValid,
    output logic                       WordReady,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       Busy,
    output logic                       Error,
    output logic                       Done
);

    // One extra bit so that idx+1 == MaxFramesPerCol never wraps.
    localparam int IdxW = $clog2(MaxFramesPerCol) + 1;
    localparam int CntW = CNT_MSB - CNT_LSB + 1;
    localparam int HdrIdxW = IDX_MSB - IDX_LSB + 1;

    localparam logic [IdxW-1:0]    MaxFramesIdx = IdxW'(MaxFramesPerCol);
    localparam logic [HdrIdxW-1:0] MaxFramesHdr = HdrIdxW'(MaxFramesPerCol);
    localparam logic [CntW-1:0]    CntOne       = CntW'(1);
    localparam logic [IdxW-1:0]    IdxOne       = IdxW'(1);

    cfg_state_t                 stateReg, stateNext;
    logic [IdxW-1:0]            idxReg, idxNext;
    logic [CntW-1:0]            cntReg, cntNext;
    logic                       dropReg, dropNext;
    logic                       errorReg, errorNext;
    logic                       doneReg, doneNext;
    logic [FrameBitsPerRow-1:0] frameDataReg, frameDataNext;

    logic                       readyState;
    logic                       accept;
    logic                       strobeEn;
    logic [HdrIdxW-1:0]         hdrIdx;
    logic [CntW-1:0]            hdrCnt;
    logic [IdxW-1:0]            idxInc;

    assign hdrIdx = WordData[IDX_MSB:IDX_LSB];
    assign hdrCnt = WordData[CNT_MSB:CNT_LSB];
    assign idxInc = idxReg + IdxOne;

    assign readyState = (stateReg == HUNT) || (stateReg == HEADER) || (stateReg == DATA);
    assign accept     = WordValid && readyState;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            stateReg     <= HUNT;
            idxReg       <= '0;
            cntReg       <= '0;
            dropReg      <= 1'b0;
            errorReg     <= 1'b0;
            doneReg      <= 1'b0;
            frameDataReg <= '0;
        end else begin
            stateReg     <= stateNext;
            idxReg       <= idxNext;
            cntReg       <= cntNext;
            dropReg      <= dropNext;
            errorReg     <= errorNext;
            doneReg      <= doneNext;
            frameDataReg <= frameDataNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        stateNext     = stateReg;
        idxNext       = idxReg;
        cntNext       = cntReg;
        dropNext      = dropReg;
        errorNext     = errorReg;
        doneNext      = 1'b0;
        frameDataNext = frameDataReg;

        unique case (stateReg)
            HUNT: begin
                if (accept && (WordData == SyncWord)) begin
                    stateNext = HEADER;
                    errorNext = 1'b0;
                end
            end

            HEADER: begin
                if (accept) begin
                    if (hdrCnt == '0) begin
                        stateNext = HUNT;
                    end else if (hdrIdx >= MaxFramesHdr) begin
                        // Out-of-range start: swallow the data words.
                        errorNext = 1'b1;
                        dropNext  = 1'b1;
                        cntNext   = hdrCnt;
                        stateNext = DATA;
                    end else begin
                        idxNext   = hdrIdx[IdxW-1:0];
                        cntNext   = hdrCnt;
                        dropNext  = 1'b0;
                        stateNext = DATA;
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    if (dropReg) begin
                        cntNext = cntReg - CntOne;
                        if (cntReg == CntOne) begin
                            stateNext = HUNT;
                        end
                    end else begin
                        frameDataNext = WordData[FrameBitsPerRow-1:0];
                        stateNext     = SETUP;
                    end
                end
            end

            SETUP: begin
                stateNext = STROBE;
            end

            STROBE: begin
                stateNext = HOLD;
            end

            HOLD: begin
                cntNext = cntReg - CntOne;
                idxNext = idxInc;
                if (cntReg == CntOne) begin
                    doneNext  = 1'b1;
                    stateNext = HUNT;
                end else if (idxInc == MaxFramesIdx) begin
                    // Ran off the end of the column with words still owed.
                    errorNext = 1'b1;
                    dropNext  = 1'b1;
                    stateNext = DATA;
                end else begin
                    stateNext = DATA;
                end
            end

            default: begin
                stateNext = HUNT;
            end
        endcase
    end

    // The decoder registers its pattern on the SETUP->STROBE edge, so the
    // strobe is high exactly while the FSM sits in STROBE.
    assign strobeEn = (stateReg == SETUP);

    frame_strobe_decoder #(
        .Width (MaxFramesPerCol),
        .IdxW  (IdxW)
    ) u_strobe (
        .clk    (CLK),
        .rst    (reset),
        .en     (strobeEn),
        .idx    (idxReg),
        .strobe (FrameStrobe)
    );

    // WordReady is forced low while reset is held, not just after an edge.
    assign WordReady = readyState && !reset;
    assign FrameData = frameDataReg;
    assign Busy      = (stateReg != HUNT);
    assign Error     = errorReg;
    assign Done      = doneReg;

endmodule

// File: tb/tb_config_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_config_frame_writer
// Self-checking bench for config_frame_writer: directed scenarios followed by
// randomized transactions, checked every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_config_frame_writer;

    localparam int          NF   = 20;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic        CLK;
    logic        reset;
    logic [31:0] WordData;
    logic        WordValid;
    logic        WordReady;
    logic [31:0] FrameData;
    logic [NF-1:0] FrameStrobe;
    logic        Busy;
    logic        Error;
    logic        Done;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    config_frame_writer #(
        .MaxFramesPerCol (NF),
        .FrameBitsPerRow (32),
        .SyncWord        (SYNC)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .WordData    (WordData),
        .WordValid   (WordValid),
        .WordReady   (WordReady),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .Busy        (Busy),
        .Error       (Error),
        .Done        (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: protocol phase plus a countdown of the cycles the
    // writer spends presenting a frame (setup, strobe, hold).
    // ------------------------------------------------------------------
    int          mPhase;     // 0 = waiting for sync, 1 = header, 2 = data
    int          mGap;       // remaining not-ready cycles of a frame write
    int          mIdx;
    int          mRem;
    int          mStrobeIdx;
    bit          mDrop;
    bit          mErr;
    bit          mDone;
    logic [31:0] mData;

    always @(posedge CLK) begin
        if (reset) begin
            mPhase = 0; mGap = 0; mIdx = 0; mRem = 0; mStrobeIdx = 0;
            mDrop = 0; mErr = 0; mDone = 0; mData = '0;
        end else begin
            mDone = 0;
            if (mGap > 0) begin
                mGap--;
                if (mGap == 0) begin
                    mRem--;
                    mIdx++;
                    if (mRem == 0) begin
                        mDone  = 1;
                        mPhase = 0;
                    end else if (mIdx == NF) begin
                        mErr  = 1;
                        mDrop = 1;
                    end
                end
            end else if (WordValid) begin
                case (mPhase)
                    0: if (WordData == SYNC) begin
                        mPhase = 1;
                        mErr   = 0;
                    end
                    1: begin
                        if (WordData[15:8] == 0) begin
                            mPhase = 0;
                        end else begin
                            mRem   = int'(WordData[15:8]);
                            mIdx   = int'(WordData[7:0]);
                            mDrop  = (mIdx >= NF);
                            if (mDrop) mErr = 1;
                            mPhase = 2;
                        end
                    end
                    default: begin
                        if (mDrop) begin
                            mRem--;
                            if (mRem == 0) mPhase = 0;
                        end else begin
                            mData      = WordData;
                            mStrobeIdx = mIdx;
                            mGap       = 3;
                        end
                    end
                endcase
            end
        end
    end

    // Strobe log taken from the DUT, pinned by literal expectations.
    int strobeIdxLog[$];
    int strobeCycLog[$];
    int doneCount;

    always @(negedge CLK) begin
        logic [NF-1:0] expStrobe;
        logic [NF-1:0] one;
        one = 1;
        if (reset) begin
            chk("rst_ready",  {31'b0, WordReady}, 32'd0);
            chk("rst_strobe", 32'(FrameStrobe), 32'd0);
            chk("rst_busy",   {31'b0, Busy}, 32'd0);
            chk("rst_error",  {31'b0, Error}, 32'd0);
            chk("rst_done",   {31'b0, Done}, 32'd0);
            chk("rst_data",   FrameData, 32'd0);
        end else begin
            expStrobe = (mGap == 2) ? (one << mStrobeIdx) : '0;
            chk("ready",  {31'b0, WordReady}, {31'b0, (mGap == 0)});
            chk("strobe", 32'(FrameStrobe), 32'(expStrobe));
            chk("busy",   {31'b0, Busy}, {31'b0, (mPhase != 0 || mGap != 0)});
            chk("error",  {31'b0, Error}, {31'b0, mErr});
            chk("done",   {31'b0, Done}, {31'b0, mDone});
            chk("data",   FrameData, mData);
            if (FrameStrobe != '0) begin
                for (int b = 0; b < NF; b++) begin
                    if (FrameStrobe[b]) begin
                        strobeIdxLog.push_back(b);
                        strobeCycLog.push_back(cycle);
                    end
                end
            end
            if (Done) doneCount++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic sendWord(input logic [31:0] w);
        int t;
        WordData  = w;
        WordValid = 1'b1;
        t = 0;
        @(negedge CLK);
        while (!WordReady && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got ready=0 for 100 cycles, expected ready=1 (word %h)", w);
        end
        @(posedge CLK);
        #1;
        WordValid = 1'b0;
    endtask

    task automatic idle(input int n);
        WordValid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clearLog();
        strobeIdxLog.delete();
        strobeCycLog.delete();
        doneCount = 0;
    endtask

    task automatic hdr(input int idx, input int cnt, output logic [31:0] w);
        w = {16'h0, 8'(cnt), 8'(idx)};
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] h;
        int ntx;
        reset     = 1'b1;
        WordValid = 1'b0;
        WordData  = '0;
        doneCount = 0;
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b0;
        idle(2);

        // 1: single frame at idx 3
        clearLog();
        hdr(3, 1, h);
        sendWord(SYNC); sendWord(h); sendWord(32'hDEADBEEF);
        idle(6);
        $display("txn1: sync idx=3 cnt=1 data=DEADBEEF");
        chk("t1_data", FrameData, 32'hDEADBEEF);
        chk("t1_nstrobe", strobeIdxLog.size(), 1);
        if (strobeIdxLog.size() == 1) chk("t1_bit", strobeIdxLog[0], 3);
        chk("t1_done", doneCount, 1);
        chk("t1_error", {31'b0, Error}, 32'd0);

        // 2: run off the end of the column
        clearLog();
        hdr(18, 3, h);
        sendWord(SYNC); sendWord(h);
        sendWord(32'hAAAA_0001); sendWord(32'hBBBB_0002); sendWord(32'hCCCC_0003);
        idle(6);
        $display("txn2: sync idx=18 cnt=3 three data words");
        chk("t2_nstrobe", strobeIdxLog.size(), 2);
        if (strobeIdxLog.size() == 2) begin
            chk("t2_bitA", strobeIdxLog[0], 18);
            chk("t2_bitB", strobeIdxLog[1], 19);
        end
        chk("t2_error", {31'b0, Error}, 32'd1);
        chk("t2_done", doneCount, 0);
        chk("t2_busy", {31'b0, Busy}, 32'd0);

        // 3: junk words then zero-count header
        clearLog();
        hdr(0, 0, h);
        sendWord(32'h0); sendWord(32'h12345678); sendWord(SYNC); sendWord(h);
        idle(3);
        $display("txn3: junk, sync, cnt=0 header");
        chk("t3_nstrobe", strobeIdxLog.size(), 0);
        chk("t3_busy", {31'b0, Busy}, 32'd0);
        chk("t3_error", {31'b0, Error}, 32'd0);

        // 4: out-of-range header, words dropped, next sync clears Error
        clearLog();
        hdr(25, 2, h);
        sendWord(SYNC); sendWord(h); sendWord(32'h1111_1111); sendWord(32'h2222_2222);
        idle(3);
        $display("txn4: sync idx=25 cnt=2 dropped");
        chk("t4_nstrobe", strobeIdxLog.size(), 0);
        chk("t4_error", {31'b0, Error}, 32'd1);
        chk("t4_busy", {31'b0, Busy}, 32'd0);
        sendWord(SYNC);
        idle(1);
        chk("t4_error_clr", {31'b0, Error}, 32'd0);
        hdr(0, 0, h);
        sendWord(h);
        idle(2);

        // 5: back-to-back burst of 4 frames from idx 0
        clearLog();
        hdr(0, 4, h);
        sendWord(SYNC); sendWord(h);
        for (int i = 0; i < 4; i++) sendWord(32'h5000_0000 + 32'(i));
        idle(6);
        $display("txn5: sync idx=0 cnt=4 back-to-back");
        chk("t5_nstrobe", strobeIdxLog.size(), 4);
        if (strobeIdxLog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t5_bit", strobeIdxLog[i], i);
            for (int i = 1; i < 4; i++) chk("t5_spacing", strobeCycLog[i] - strobeCycLog[i-1], 4);
        end
        chk("t5_data", FrameData, 32'h5000_0003);
        chk("t5_done", doneCount, 1);

        // 6: reset asserted during the strobe cycle
        clearLog();
        hdr(5, 2, h);
        sendWord(SYNC); sendWord(h); sendWord(32'h6666_6666);
        @(posedge CLK);
        #1;
        chk("t6_strobe_on", 32'(FrameStrobe), 32'h0000_0020);
        reset = 1'b1;
        #1;
        chk("t6_strobe_async", 32'(FrameStrobe), 32'd0);
        chk("t6_busy_async", {31'b0, Busy}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        reset = 1'b0;
        idle(2);
        chk("t6_busy_after", {31'b0, Busy}, 32'd0);
        clearLog();
        hdr(7, 1, h);
        sendWord(SYNC); sendWord(h); sendWord(32'h7777_7777);
        idle(6);
        $display("txn6: reset mid-strobe, then idx=7 cnt=1");
        chk("t6_nstrobe", strobeIdxLog.size(), 1);
        if (strobeIdxLog.size() == 1) chk("t6_bit", strobeIdxLog[0], 7);
        chk("t6_done", doneCount, 1);
        chk("t6_data", FrameData, 32'h7777_7777);

        // Randomized transactions against the model
        ntx = 40;
        for (int t = 0; t < ntx; t++) begin
            int idx, cnt;
            idx = $urandom_range(0, 24);
            cnt = $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) sendWord($urandom & 32'hFFFF_FF00);
            sendWord(SYNC);
            idle($urandom_range(0, 2));
            sendWord({16'($urandom), 8'(cnt), 8'(idx)});
            for (int k = 0; k < cnt; k++) begin
                idle($urandom_range(0, 2));
                sendWord($urandom);
            end
            idle($urandom_range(0, 3));
            $display("rand txn %0d: idx=%0d cnt=%0d", t, idx, cnt);
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
